// File: rtl/radix_2_dif_intt_pe_pkg.sv
// Shared constants for the Gentleman-Sande inverse-NTT butterfly: modulus, Barrett
// constant and the optional halving helper.
package radix_2_dif_intt_pe_pkg;
  localparam int N    = 17;
  localparam int TAGW = 8;
  localparam logic [N-1:0] Q      = 17'd65537;
  localparam logic [N-1:0] TWOINV = 17'd32769;

  // Full-width Barrett: floor(p*MU / 2^(2N)) underestimates p/Q by at most one
  localparam int RED_SHIFT = 2*N;
  localparam logic [N:0] MU = (N+1)'((64'd1 << RED_SHIFT) / 64'(Q));

  function automatic logic [N-1:0] half_mod(input logic [N-1:0] x);
    logic [N:0] t;
    t = x[0] ? ({1'b0, x} + {1'b0, Q}) : {1'b0, x};
    return N'(t >> 1);
  endfunction
endpackage

// File: rtl/radix_2_dif_intt_pe_if.sv
// Operand/result stream of the INTT butterfly; master drives operands and out_ready.
interface radix_2_dif_intt_pe_if;
  import radix_2_dif_intt_pe_pkg::*;
  logic            in_valid, in_ready;
  logic [N-1:0]    a0, a1, tf;
  logic [TAGW-1:0] in_tag;
  logic            out_valid, out_ready;
  logic [N-1:0]    A0, A1;
  logic [TAGW-1:0] out_tag;

  modport master (output in_valid, a0, a1, tf, in_tag, out_ready,
                  input  in_ready, out_valid, A0, A1, out_tag);
  modport slave  (input  in_valid, a0, a1, tf, in_tag, out_ready,
                  output in_ready, out_valid, A0, A1, out_tag);
endinterface

// File: rtl/radix_2_dif_intt_pe_modred_mul_pipe.sv
// Two-stage modular multiply: registered N x N product, then registered Barrett
// reduction with a single conditional subtract. Both stages hold when en is low.
module modred_mul_pipe
  import radix_2_dif_intt_pe_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] d,
  input  logic [N-1:0] tf,
  output logic [N-1:0] r
);
  logic [2*N-1:0] p_q, p_d;
  logic [N-1:0]   r_q, r_d;
  logic [3*N:0]   qm;
  logic [N:0]     qest, rem, rsub;
  logic [2*N-1:0] rem_full;

  always_comb begin
    p_d      = p_q;
    r_d      = r_q;
    qm       = {{(N+1){1'b0}}, p_q} * {{(2*N){1'b0}}, MU};
    qest     = (N+1)'(qm >> RED_SHIFT);
    rem_full = p_q - ({{(N-1){1'b0}}, qest} * {{N{1'b0}}, Q});
    // remainder is below 2Q, so N+1 bits hold it exactly
    rem      = (N+1)'(rem_full);
    rsub     = rem - {1'b0, Q};
    if (en) begin
      p_d = {{N{1'b0}}, d} * {{N{1'b0}}, tf};
      r_d = (rem >= {1'b0, Q}) ? N'(rsub) : N'(rem);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
      r_q <= '0;
    end else begin
      p_q <= p_d;
      r_q <= r_d;
    end
  end

  assign r = r_q;
endmodule

// File: rtl/radix_2_dif_intt_pe.sv
// Pipelined GS/DIF inverse-NTT butterfly: A0=(a0+a1) mod Q, A1=(a0-a1)*tf mod Q.
// Define INTT_HALVE_EN to add a fourth stage scaling both results by 2^-1 mod Q.
module radix_2_dif_intt_pe
  import radix_2_dif_intt_pe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  radix_2_dif_intt_pe_if.slave  bus
);
`ifdef INTT_HALVE_EN
  localparam int STAGES = 4;
`else
  localparam int STAGES = 3;
`endif

  logic                       adv;
  logic [STAGES:1]            vld_q, vld_d;
  logic [STAGES:1][TAGW-1:0]  tag_q, tag_d;
  logic [N-1:0]               s1_q, s1_d, d1_q, d1_d, tf1_q, tf1_d;
  logic [N-1:0]               s2_q, s2_d, s3_q, s3_d;
  logic [N-1:0]               prod_red;
  logic [N:0]                 sum, dif;
`ifdef INTT_HALVE_EN
  logic [N-1:0]               h0_q, h0_d, h1_q, h1_d;
`endif

  // Whole pipe moves in lockstep; a stalled output freezes every stage
  assign adv          = !vld_q[STAGES] | bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    s1_d  = s1_q;
    d1_d  = d1_q;
    tf1_d = tf1_q;
    s2_d  = s2_q;
    s3_d  = s3_q;
`ifdef INTT_HALVE_EN
    h0_d  = h0_q;
    h1_d  = h1_q;
`endif
    sum = {1'b0, bus.a0} + {1'b0, bus.a1};
    if (sum >= {1'b0, Q}) sum = sum - {1'b0, Q};
    dif = {1'b0, bus.a0} - {1'b0, bus.a1};
    if (dif[N]) dif = dif + {1'b0, Q};
    if (adv) begin
      vld_d    = {vld_q[STAGES-1:1], bus.in_valid};
      tag_d[1] = bus.in_tag;
      for (int k = 2; k <= STAGES; k++) tag_d[k] = tag_q[k-1];
      s1_d  = N'(sum);
      d1_d  = N'(dif);
      tf1_d = bus.tf;
      s2_d  = s1_q;
      s3_d  = s2_q;
`ifdef INTT_HALVE_EN
      h0_d  = half_mod(s3_q);
      h1_d  = half_mod(prod_red);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      tag_q <= '0;
      s1_q  <= '0;
      d1_q  <= '0;
      tf1_q <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
`ifdef INTT_HALVE_EN
      h0_q  <= '0;
      h1_q  <= '0;
`endif
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      s1_q  <= s1_d;
      d1_q  <= d1_d;
      tf1_q <= tf1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
`ifdef INTT_HALVE_EN
      h0_q  <= h0_d;
      h1_q  <= h1_d;
`endif
    end
  end

  modred_mul_pipe u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .d     (d1_q),
    .tf    (tf1_q),
    .r     (prod_red)
  );

  assign bus.out_valid = vld_q[STAGES];
  assign bus.out_tag   = tag_q[STAGES];
`ifdef INTT_HALVE_EN
  assign bus.A0 = h0_q;
  assign bus.A1 = h1_q;
`else
  assign bus.A0 = s3_q;
  assign bus.A1 = prod_red;
`endif
endmodule

// File: tb/tb_radix_2_dif_intt_pe.sv
// Self-checking bench for radix_2_dif_intt_pe: directed vectors, backpressure,
// mid-flight reset and a long random run against a % Q reference model.
module tb_radix_2_dif_intt_pe;
  localparam int N    = 17;
  localparam int TAGW = 8;
  localparam longint unsigned QM = 65537;
  localparam longint unsigned HV = 32769;
`ifdef INTT_HALVE_EN
  localparam int L = 4;
`else
  localparam int L = 3;
`endif

  typedef struct packed {
    logic [N-1:0]    r0;
    logic [N-1:0]    r1;
    logic [TAGW-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  radix_2_dif_intt_pe_if bus();

  radix_2_dif_intt_pe dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;
  exp_t sb[$];
  logic h_stall;
  logic [N-1:0]    h_a0, h_a1;
  logic [TAGW-1:0] h_tag;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", nm, obs, exp);
    end
  endtask

  function automatic void ref_bf(input longint unsigned a0, a1, tf,
                                 output longint unsigned r0, r1);
    r0 = (a0 + a1) % QM;
    r1 = (((a0 + QM - a1) % QM) * tf) % QM;
`ifdef INTT_HALVE_EN
    r0 = (r0 * HV) % QM;
    r1 = (r1 * HV) % QM;
`endif
  endfunction

  function automatic logic [N-1:0] rq();
    int unsigned sel;
    sel = $urandom_range(7, 0);
    if (sel == 0) return '0;
    if (sel == 1) return N'(QM - 1);
    return N'($urandom_range(65536, 0));
  endfunction

  // One cycle: drive at negedge, judge what the coming posedge will transfer
  task automatic cyc(input logic iv, input logic [N-1:0] a0, a1, tf,
                     input logic [TAGW-1:0] tag, input logic ordy, output logic acc);
    exp_t e;
    longint unsigned r0, r1;
    @(negedge clk);
    if (h_stall) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_A0", bus.A0, h_a0);
      chk("hold_A1", bus.A1, h_a1);
      chk("hold_tag", bus.out_tag, h_tag);
    end
    bus.in_valid  = iv;
    bus.a0        = a0;
    bus.a1        = a1;
    bus.tf        = tf;
    bus.in_tag    = tag;
    bus.out_ready = ordy;
    #1;
    chk("in_ready", bus.in_ready, !bus.out_valid || ordy);
    if (bus.out_valid && sb.size() == 0) begin
      chk("out_unexpected", bus.out_valid, 0);
    end else if (bus.out_valid && ordy) begin
      e = sb.pop_front();
      chk("A0", bus.A0, e.r0);
      chk("A1", bus.A1, e.r1);
      chk("tag", bus.out_tag, e.tag);
      n_out++;
    end
    acc = iv && bus.in_ready;
    if (acc) begin
      ref_bf(a0, a1, tf, r0, r1);
      e.r0 = N'(r0);
      e.r1 = N'(r1);
      e.tag = tag;
      sb.push_back(e);
    end
    h_stall = bus.out_valid && !ordy;
    h_a0 = bus.A0;
    h_a1 = bus.A1;
    h_tag = bus.out_tag;
  endtask

  task automatic directed(input string nm, input logic [N-1:0] a0, a1, tf,
                          input logic [N-1:0] e0, e1);
    logic acc;
    cyc(1'b1, a0, a1, tf, 8'hA5, 1'b1, acc);
    chk({nm, "_acc"}, acc, 1);
    for (int k = 1; k < L; k++) begin
      cyc(1'b0, '0, '0, '0, '0, 1'b1, acc);
      chk({nm, "_early"}, bus.out_valid, 0);
    end
    cyc(1'b0, '0, '0, '0, '0, 1'b1, acc);
    chk({nm, "_valid"}, bus.out_valid, 1);
    chk({nm, "_A0"}, bus.A0, e0);
    chk({nm, "_A1"}, bus.A1, e1);
  endtask

  initial begin
    logic acc;
    int   idx, nacc, out0;
    bus.in_valid = 1'b0; bus.a0 = '0; bus.a1 = '0; bus.tf = '0;
    bus.in_tag = '0; bus.out_ready = 1'b0;
    h_stall = 1'b0; h_a0 = '0; h_a1 = '0; h_tag = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_A0", bus.A0, 0);
    chk("rst_A1", bus.A1, 0);
    chk("rst_tag", bus.out_tag, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    #1 rst_n = 1'b1;

`ifdef INTT_HALVE_EN
    directed("basic", 17'd5, 17'd3, 17'd1, 17'd4, 17'd1);
    directed("wrap", 17'd1, 17'd2, 17'd1, 17'd32770, 17'd32768);
    directed("mul_a", 17'd2, 17'd0, 17'd65536, 17'd1, 17'd65536);
    directed("mul_b", 17'd65536, 17'd65536, 17'd65536, 17'd65536, 17'd0);
`else
    directed("basic", 17'd5, 17'd3, 17'd1, 17'd8, 17'd2);
    directed("wrap", 17'd1, 17'd2, 17'd1, 17'd3, 17'd65536);
    directed("mul_a", 17'd2, 17'd0, 17'd65536, 17'd2, 17'd65535);
    directed("mul_b", 17'd65536, 17'd65536, 17'd65536, 17'd65535, 17'd0);
`endif

    // backpressure: tags 0..7, out_ready low for 5 cycles mid-stream
    idx = 0;
    out0 = n_out;
    for (int c = 0; c < 80 && (idx < 8 || sb.size() > 0); c++) begin
      cyc(idx < 8, rq(), rq(), rq(), TAGW'(idx), !(c >= 4 && c < 9), acc);
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 8);
    chk("bp_drained", sb.size(), 0);
    chk("bp_delivered", n_out - out0, 8);

    // reset pulse between edges with results in flight
    for (int i = 0; i < 3; i++) cyc(1'b1, rq(), rq(), rq(), TAGW'(8'h40 + i), 1'b1, acc);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_A0", bus.A0, 0);
    chk("midrst_A1", bus.A1, 0);
    chk("midrst_tag", bus.out_tag, 0);
    sb.delete();
    h_stall = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < L + 2; i++) begin
      cyc(1'b0, '0, '0, '0, '0, 1'b1, acc);
      chk("post_rst_idle", bus.out_valid, 0);
    end
`ifdef INTT_HALVE_EN
    directed("post_rst", 17'd5, 17'd3, 17'd1, 17'd4, 17'd1);
`else
    directed("post_rst", 17'd5, 17'd3, 17'd1, 17'd8, 17'd2);
`endif

    // random operands with random valid and out_ready
    nacc = 0;
    for (int c = 0; c < 40000 && nacc < 10000; c++) begin
      cyc($urandom_range(9, 0) < 8, rq(), rq(), rq(), TAGW'($urandom_range(255, 0)),
          $urandom_range(3, 0) != 0, acc);
      if (acc) nacc++;
    end
    chk("rand_accepted", nacc, 10000);
    for (int c = 0; c < 40 && sb.size() > 0; c++) cyc(1'b0, '0, '0, '0, '0, 1'b1, acc);
    chk("rand_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
